// File: rtl/systemfinal_result_from_fpga.sv
// -----------------------------------------------------------------------------
// systemfinal_result_from_fpga
//
// Avalon-MM slave that returns TPU result words and status from the FPGA
// fabric to the HPS. The fabric pushes 32-bit words through a valid/ready
// handshake into a small FIFO. The HPS pops words, reads status, and receives
// a level interrupt when data is pending or an error flag is set.
//
// Register map (address):
//   0 DATA    read : head word, pops it; when empty returns 0 and sets sticky[0]
//             write: ignored, sets sticky[1] (illegal write)
//   1 STATUS  read : [0] not_empty, [1] full, [8+CNT_W-1:8] count
//   2 IRQMASK read/write [1:0]
//   3 STICKY  read [1:0], write-1-to-clear (a set in the same cycle wins)
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   address    register select
//   chipselect slave select
//   read       read strobe, qualified by chipselect
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data
//   readdata   registered read data, valid one cycle after the read strobe
//   in_data    result word from the TPU
//   in_valid   in_data is valid
//   in_ready   FIFO can accept a word (from the registered count)
//   irq        registered level interrupt to the HPS
// -----------------------------------------------------------------------------
module systemfinal_result_from_fpga #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        irq
);

   localparam int unsigned PTR_W = (CNT_W > 1) ? CNT_W - 1 : 1;

   typedef enum logic [1:0] {
      REG_DATA    = 2'd0,
      REG_STATUS  = 2'd1,
      REG_IRQMASK = 2'd2,
      REG_STICKY  = 2'd3
   } reg_addr_e;

   // FIFO state
   logic [31:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Register state
   logic [31:0]      readdata_q, readdata_d;
   logic [1:0]       irqmask_q, irqmask_d;
   logic [1:0]       sticky_q, sticky_d;
   logic             irq_q, irq_d;

   // Decode and handshake
   reg_addr_e        addr_e;
   logic             rd_sel;
   logic             wr_sel;
   logic             pop_req;
   logic             push;
   logic             pop;
   logic             underflow;
   logic             illegal_wr;
   logic             not_empty;
   logic             full;
   logic [31:0]      head;
   logic [31:0]      status;
   logic [1:0]       sticky_clr;
   logic             unused_wdata;

   assign addr_e     = reg_addr_e'(address);
   assign rd_sel     = chipselect & read;
   assign wr_sel     = chipselect & ~write_n;

   assign not_empty  = (count_q != '0);
   assign full       = (count_q == CNT_W'(DEPTH));
   assign in_ready   = ~full;

   assign push       = in_valid & in_ready;
   assign pop_req    = rd_sel & (addr_e == REG_DATA);
   assign pop        = pop_req & not_empty;
   assign underflow  = pop_req & ~not_empty;
   assign illegal_wr = wr_sel & (addr_e == REG_DATA);

   assign head       = mem_q[rd_ptr_q];

   // Only the low two bits of writedata are architecturally visible.
   assign unused_wdata = ^writedata[31:2];

   // ---------------------------------------------------------------------------
   // FIFO pointer / occupancy next state
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // ---------------------------------------------------------------------------
   // STATUS word
   // ---------------------------------------------------------------------------
   always_comb begin
      status            = '0;
      status[0]         = not_empty;
      status[1]         = full;
      status[8 +: CNT_W] = count_q;
   end

   // ---------------------------------------------------------------------------
   // Read data path: held when not selected
   // ---------------------------------------------------------------------------
   always_comb begin
      readdata_d = readdata_q;
      if (rd_sel) begin
         case (addr_e)
            REG_DATA:    readdata_d = pop ? head : '0;
            REG_STATUS:  readdata_d = status;
            REG_IRQMASK: readdata_d = {30'd0, irqmask_q};
            REG_STICKY:  readdata_d = {30'd0, sticky_q};
            default:     readdata_d = '0;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Control registers and interrupt
   // ---------------------------------------------------------------------------
   always_comb begin
      irqmask_d  = irqmask_q;
      sticky_clr = '0;
      if (wr_sel && (addr_e == REG_IRQMASK)) begin
         irqmask_d = writedata[1:0];
      end
      if (wr_sel && (addr_e == REG_STICKY)) begin
         sticky_clr = writedata[1:0];
      end
      // Clear is applied first so that a same-cycle set survives.
      sticky_d = (sticky_q & ~sticky_clr) | {illegal_wr, underflow};

      // Computed from next-state values so irq is registered alongside the
      // state that causes it, appearing one cycle after the causing strobe.
      irq_d = (irqmask_d[0] & (count_d != '0)) |
              (irqmask_d[1] & (sticky_d[0] | sticky_d[1]));
   end

   // ---------------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         readdata_q <= '0;
         irqmask_q  <= '0;
         sticky_q   <= '0;
         irq_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         readdata_q <= readdata_d;
         irqmask_q  <= irqmask_d;
         sticky_q   <= sticky_d;
         irq_q      <= irq_d;
      end
   end

   // Storage is not reset; a write while reset is high is harmless because the
   // pointers and count are cleared in the same edge.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_systemfinal_result_from_fpga.sv
module tb_systemfinal_result_from_fpga;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        irq;

   always #5 clk = ~clk;

   systemfinal_result_from_fpga #(
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .chipselect(chipselect),
      .read      (read),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .irq       (irq)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Scoreboard of expected readdata, one entry per issued read strobe.
   logic [31:0] exp_q[$];
   string       tag_q[$];
   bit          rd_pend = 1'b0;

   // Reference model state.
   logic [31:0] mq[$];
   logic [1:0]  m_mask   = 2'b00;
   logic [1:0]  m_sticky = 2'b00;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      int unsigned cnt;
      cnt = mq.size();
      s = '0;
      s[0] = (cnt != 0);
      s[1] = (cnt == DEPTH);
      s[8 +: CNT_W] = CNT_W'(cnt);
      return s;
   endfunction

   function automatic logic [31:0] m_irq();
      return {31'd0, (m_mask[0] && mq.size() != 0) || (m_mask[1] && (m_sticky != 2'b00))};
   endfunction

   // Advance one clock; sample 1 ns after the edge and retire a pending read.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (rd_pend) begin
         rd_pend = 1'b0;
         if (exp_q.size() != 0)
            check_eq(tag_q.pop_front(), readdata, exp_q.pop_front());
         else
            check_eq("sb_size", 32'(exp_q.size()), 32'd1);
      end
   endtask

   task automatic end_bus();
      chipselect = 1'b0;
      read       = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic issue_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
      address    = a;
      chipselect = 1'b1;
      read       = 1'b1;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      rd_pend    = 1'b1;
   endtask

   task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
      issue_read(a, exp, tag);
      cycle();
      end_bus();
   endtask

   task automatic do_pop(input string tag);
      logic [31:0] e;
      if (mq.size() != 0) begin
         e = mq.pop_front();
      end else begin
         e = 32'd0;
         m_sticky[0] = 1'b1;
      end
      do_read(2'd0, e, tag);
   endtask

   task automatic do_push(input logic [31:0] w, input string tag);
      check_eq({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = w;
      mq.push_back(w);
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      if (a == 2'd2) m_mask = d[1:0];
      if (a == 2'd3) m_sticky = m_sticky & ~d[1:0];
      if (a == 2'd0) m_sticky[1] = 1'b1;
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      cycle();
      end_bus();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] e;
      reset      = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      read       = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_data    = 32'hDEAD_BEEF;
      in_valid   = 1'b1;           // must be ignored while reset is high
      repeat (3) cycle();
      reset    = 1'b0;
      in_valid = 1'b0;

      // Reset state
      check_eq("rst_readdata", readdata, 32'd0);
      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("rst_irq", {31'd0, irq}, 32'd0);
      do_read(2'd1, m_status(), "rst_status");
      do_read(2'd2, 32'd0, "rst_irqmask");
      do_read(2'd3, 32'd0, "rst_sticky");

      // Fill to full, then drain in order
      for (int unsigned i = 1; i <= 4; i++) do_push(32'hA5A5_0000 + i, "fill");
      check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
      do_read(2'd1, 32'h0000_0403, "full_status");
      for (int unsigned i = 0; i < 4; i++) do_pop("drain");
      do_read(2'd1, m_status(), "drained_status");

      // Underflow, sticky interrupt, W1C
      do_pop("pop_empty");
      do_read(2'd3, {30'd0, m_sticky}, "sticky_uf");
      do_write(2'd2, 32'h2);
      check_eq("irq_sticky_on", {31'd0, irq}, m_irq());
      do_write(2'd3, 32'h1);
      check_eq("irq_sticky_off", {31'd0, irq}, m_irq());
      do_read(2'd3, {30'd0, m_sticky}, "sticky_cleared");
      do_write(2'd0, 32'h1234);
      check_eq("irq_illegal_wr", {31'd0, irq}, m_irq());
      do_write(2'd1, 32'h3);
      do_read(2'd3, {30'd0, m_sticky}, "sticky_illegal");
      do_write(2'd3, 32'h2);
      check_eq("irq_illegal_off", {31'd0, irq}, m_irq());
      do_write(2'd2, 32'h0);

      // Simultaneous push and pop with one word queued
      do_push(32'h11, "pp_setup");
      e = mq.pop_front();
      mq.push_back(32'h22);
      in_valid = 1'b1;
      in_data  = 32'h22;
      issue_read(2'd0, e, "pp_head");
      cycle();
      in_valid = 1'b0;
      end_bus();
      do_read(2'd1, m_status(), "pp_status");
      do_pop("pp_next");

      // Simultaneous push and pop while empty
      m_sticky[0] = 1'b1;
      mq.push_back(32'h33);
      in_valid = 1'b1;
      in_data  = 32'h33;
      issue_read(2'd0, 32'd0, "pp_empty");
      cycle();
      in_valid = 1'b0;
      end_bus();
      do_read(2'd1, m_status(), "pp_empty_status");
      do_read(2'd3, {30'd0, m_sticky}, "pp_empty_sticky");
      do_write(2'd3, 32'h1);
      do_pop("pp_empty_word");

      // Full FIFO, pop while a word is held on the input
      for (int unsigned i = 0; i < 4; i++) do_push(32'hB0 + i, "full2");
      in_valid = 1'b1;
      in_data  = 32'hB4;
      e = mq.pop_front();
      issue_read(2'd0, e, "full_pop");
      check_eq("full_rdy_pre", {31'd0, in_ready}, 32'd0);
      cycle();
      end_bus();
      check_eq("full_rdy_next", {31'd0, in_ready}, 32'd1);
      mq.push_back(32'hB4);
      cycle();
      in_valid = 1'b0;
      check_eq("full_refill", {31'd0, in_ready}, 32'd0);
      for (int unsigned i = 0; i < 4; i++) do_pop("full_drain");
      do_read(2'd1, m_status(), "full_final_status");

      // Not-empty interrupt, then reset mid-stream
      do_write(2'd2, 32'h1);
      do_push(32'hC0, "irq_push");
      check_eq("irq_not_empty", {31'd0, irq}, m_irq());
      do_push(32'hC1, "q2");
      do_push(32'hC2, "q3");
      do_read(2'd1, m_status(), "pre_reset_status");
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hC3;
      cycle();
      reset    = 1'b0;
      in_valid = 1'b0;
      mq.delete();
      m_mask   = 2'b00;
      m_sticky = 2'b00;
      check_eq("mid_rst_readdata", readdata, 32'd0);
      check_eq("mid_rst_irq", {31'd0, irq}, 32'd0);
      check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      do_read(2'd1, m_status(), "mid_rst_status");
      do_read(2'd2, 32'd0, "mid_rst_irqmask");

      check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/systemfinal_result_from_fpga.md
Name: systemfinal_result_from_FPGA

Overview:
- Avalon-MM slave that returns TPU results and status from the FPGA fabric to the HPS.
- Counterpart to the HPS-to-FPGA control output port.
- Fabric side pushes 32-bit words through a valid/ready handshake into a small FIFO.
- HPS side pops words, reads status, and takes a level interrupt when data is pending or an error is flagged.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- CNT_W, 3, width of the occupancy count, equal to log2(DEPTH)+1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  2  register select
- chipselect  in  1  slave select
- read  in  1  read strobe, qualified by chipselect
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_data  in  32  result word from the TPU
- in_valid  in  1  in_data is valid
- in_ready  out  1  FIFO can accept a word
- irq  out  1  level interrupt to the HPS

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on the reset port.
- Reset values:
  - readdata = 0; FIFO empty, count = 0; in_ready = 1.
  - irqmask = 0; sticky = 0; irq = 0.
  - FIFO storage contents are don't-care.
- Push: occurs on a clk edge where in_valid && in_ready. in_ready = (count != DEPTH), driven combinationally from registered count.
- Pop: occurs when chipselect && read && address==0 and count != 0.
- Read latency is 1 cycle: readdata is registered at the edge after the read strobe.
- Register map, reads:
  - 0 DATA: head word, and pops it. If empty, returns 0, sets sticky[0] (underflow), no pop.
  - 1 STATUS: [0] not_empty, [1] full, [8+CNT_W-1:8] count, all other bits 0. No side effect.
  - 2 IRQMASK: [1:0] mask, upper bits 0.
  - 3 STICKY: [1:0] sticky flags, upper bits 0.
- Register map, writes (chipselect && ~write_n):
  - 2: irqmask <= writedata[1:0].
  - 3: write-1-to-clear, sticky <= sticky & ~writedata[1:0].
  - 0 and 1: ignored; a write to 0 sets sticky[1] (illegal write).
- Non-selected cycles: readdata holds its last value. A read and a write in the same cycle is not issued by the fabric; if it occurs, both take effect.
- Simultaneous push and pop:
  - Both occur; count is unchanged; the popped word is the old head.
  - When count==1, readdata gets the old head and the pushed word becomes the new head.
- Empty with pop and push in the same cycle: the pop returns 0 and sets underflow; the push still lands; count becomes 1.
- Full: in_ready=0, so no push. A pop in the same cycle does not open in_ready combinationally; in_ready rises on the next cycle.
- Sticky set and clear in the same cycle: set wins.
- Pointers: wrap modulo DEPTH; count ranges 0..DEPTH.
- irq = (irqmask[0] & not_empty) | (irqmask[1] & (sticky[0] | sticky[1])), registered, 1 cycle after the cause.
- Reset asserted mid-operation:
  - Flushes the FIFO, clears irqmask and sticky, zeroes readdata, forces in_ready=1 on the following cycle.
  - Words pending at reset are lost.
  - in_valid during reset is ignored.

Test Plan:
- Reset, then read addr 1 -> readdata=0x0 one cycle later; in_ready=1; irq=0.
- Push 0xA5A5_0001..0xA5A5_0004 (DEPTH=4) -> in_ready=0 after the 4th push; STATUS=0x0000_0403; then four reads of addr 0 -> 0xA5A5_0001..0004 in order; STATUS=0x0.
- Read addr 0 when empty -> readdata=0; STICKY=0x1; with IRQMASK=0x2, irq=1; write 0x1 to addr 3 -> STICKY=0, irq=0.
- Count=1 (head 0x11), push 0x22 and pop in the same cycle -> readdata=0x11; count stays 1; next pop returns 0x22.
- Full FIFO: pop while in_valid is held -> in_ready=1 on the next cycle only; the held word is accepted then; no word is lost or duplicated.
- IRQMASK=0x1, push one word -> irq=1 one cycle later; assert reset mid-stream with 3 words queued -> next cycle count=0, irq=0, readdata=0, IRQMASK=0.
